// File: rtl/trigger_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trigger_seq : CH-channel phase-staggered trigger pulse generator, Rev 1.0
// ---------------------------------------------------------------------------
module trigger_seq #(
   parameter int CH          = 4,
   parameter int CW          = 20,
   parameter int PW          = 12,
   parameter int BW          = 8,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic          i_clk100M,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CW-1:0] cycle,
   input  logic [PW-1:0] pulse_w,
   input  logic [CW-1:0] stagger,
   input  logic [BW-1:0] burst,
   output logic [CH-1:0] q,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
);

   localparam int            EW     = CW + PW + 4;
   localparam logic [CH-1:0] IDLE_Q = ACTIVE_HIGH ? '0 : '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic          en_d;
   logic [CW-1:0] cnt, cnt_nx;
   logic [BW-1:0] pc, pc_nx;
   logic [CW-1:0] cyc_s, stg_s;
   logic [PW-1:0] pw_s;
   logic [BW-1:0] bst_s;
   logic [CH-1:0] q_nx, act;
   logic          done_nx, err_nx, load;
   logic          cfg_ok, wrap, last_period;

   // Checked at the live inputs, in a width wide enough that no term wraps.
   logic [EW-1:0] cyc_x, pw_x, span_x;
   assign cyc_x  = EW'(cycle);
   assign pw_x   = EW'(pulse_w);
   assign span_x = EW'(CH - 1) * EW'(stagger) + pw_x;
   assign cfg_ok = (pw_x >= EW'(1)) && (cyc_x >= EW'(2)) &&
                   (pw_x < cyc_x) && (span_x <= cyc_x);

   assign wrap        = (cnt == cyc_s - CW'(1));
   assign last_period = (bst_s != '0) && (pc == bst_s - BW'(1));

   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [EW-1:0] off;
      assign off    = EW'(k) * EW'(stg_s);
      assign act[k] = (EW'(cnt) >= off) && (EW'(cnt) < off + EW'(pw_s));
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pc_nx    = pc;
      q_nx     = IDLE_Q;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      load     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (en && !en_d) begin
               if (cfg_ok) begin
                  load     = 1'b1;
                  state_nx = S_RUN;
                  cnt_nx   = '0;
                  pc_nx    = '0;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         S_RUN: begin
            // Abort is checked first so it beats a coincident burst end.
            if (!en) begin
               state_nx = S_IDLE;
            end else if (wrap && last_period) begin
               done_nx  = 1'b1;
               state_nx = S_HOLD;
            end else begin
               q_nx   = act ^ IDLE_Q;
               cnt_nx = wrap ? '0 : cnt + CW'(1);
               if (wrap && (pc != '1))
                  pc_nx = pc + BW'(1);
            end
         end
         S_HOLD: begin
            if (!en)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk100M) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         en_d    <= 1'b0;
         cnt     <= '0;
         pc      <= '0;
         q       <= IDLE_Q;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         cyc_s   <= '0;
         stg_s   <= '0;
         pw_s    <= '0;
         bst_s   <= '0;
      end else begin
         state   <= state_nx;
         en_d    <= en;
         cnt     <= cnt_nx;
         pc      <= pc_nx;
         q       <= q_nx;
         done    <= done_nx;
         cfg_err <= err_nx;
         if (load) begin
            cyc_s <= cycle;
            stg_s <= stagger;
            pw_s  <= pulse_w;
            bst_s <= burst;
         end
      end
   end

   assign busy = (state == S_RUN);

endmodule
`default_nettype wire

// File: doc/trigger_seq.md
# trigger_seq

Multi-channel, parametrised successor to the single-output ultrasonic transmit trigger. It generates CH phase-staggered trigger pulses with a runtime-programmable period, pulse width and inter-channel stagger. It supports continuous or fixed-count burst firing with a completion strobe. It sits between the acquisition control registers and the pulser drivers in the 100 MHz domain.

## Interface
Parameters:
- CH, 4, number of trigger channels (1..16)
- CW, 20, width of cycle/stagger fields and the period counter (units of 10 ns)
- PW, 12, width of the pulse-width field
- BW, 8, width of the burst-count field
- ACTIVE_HIGH, 1, asserted level of q (1: pulse high, idle low; 0: pulse low, idle high)

Ports (one clock, i_clk100M; reset rst_n is synchronous and active-low):
- i_clk100M  in  1  100 MHz clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  run request; rising edge starts, low aborts
- cycle  in  CW  period in clocks
- pulse_w  in  PW  pulse width in clocks
- stagger  in  CW  delay from channel k-1 to channel k, in clocks
- burst  in  BW  periods to fire; 0 = continuous
- q  out  CH  trigger outputs, registered
- busy  out  1  high while in RUN
- done  out  1  one-cycle strobe when a burst completes
- cfg_err  out  1  one-cycle strobe when a start is rejected

## Operation
- States are IDLE, RUN and HOLD.
- In IDLE, a start is en sampled 1 when en was 0 on the previous edge (en_d register, reset 0).
  - On a start, cycle, pulse_w, stagger and burst are copied into shadow registers.
  - Input changes after the start are ignored until the next start.
- Validity check at start, evaluated with widths extended to CW+PW+4 bits so nothing wraps:
  - pulse_w ≥ 1
  - cycle ≥ 2
  - pulse_w < cycle
  - (CH−1)·stagger + pulse_w ≤ cycle
- If the check fails: cfg_err pulses for 1 cycle, the state stays IDLE, and q stays idle. A new en rising edge is needed to retry.
- If the check passes: go to RUN with period counter cnt=0 and period count pc=0.
- RUN:
  - cnt increments each clock and wraps from cycle−1 to 0.
  - On each wrap, pc increments.
  - Channel k is active while k·stagger ≤ cnt < k·stagger + pulse_w.
  - Per-channel offsets are precomputed at start, either by accumulation over CH cycles before first fire or combinationally; a multiplier is not required per clock.
- Burst end: when burst≠0 and the wrap that completes period number burst occurs:
  - done pulses for 1 cycle.
  - The state goes to HOLD and all q return to idle.
- Continuous mode (burst=0): pc saturates and never ends the run.
- HOLD: outputs stay idle. en=0 returns to IDLE. Re-arming requires en low then high.
- en=0 in RUN aborts: next state is IDLE and q is idle on the following edge. No done strobe is issued.
- Reset in any state: state=IDLE, cnt=0, pc=0, en_d=0, q={CH{~ACTIVE_HIGH}}, busy=0, done=0, cfg_err=0.
- Reset has priority over every other event on the same edge.

## Timing
- Start detected at edge N:
  - busy=1 from edge N. If offsets are computed by accumulation, add CH cycles to every edge listed here.
  - q[0] asserts at edge N+1.
- Channel k asserts exactly k·stagger clocks after q[0].
- Every pulse is exactly pulse_w clocks wide.
- Rising edges of the same channel are exactly cycle clocks apart.
- A wrap coinciding with pulse start is seamless: with cycle = pulse_w+1, q[0] deasserts for exactly one clock per period.
- done is asserted on the same edge that q returns idle after the last pulse period. busy falls on that edge.
- Abort latency: en sampled 0 at edge M means q is idle and busy=0 after edge M+1 at the latest. Pulses in flight are truncated.
- en toggling 1→0→1 within RUN aborts, then restarts with freshly captured config.
- Simultaneous burst end and en=0: abort wins and done is not asserted.

## Test plan
- Reset with CH=4, ACTIVE_HIGH=1 → q=4'b0000, busy=0; hold reset 3 cycles mid-RUN → same values on the next edge.
- cycle=1000, pulse_w=100, stagger=0, burst=0, en rises → all four q high 100 clocks, low 900, repeating; period measured 1000 ± 0.
- cycle=1000, pulse_w=50, stagger=200, burst=3 → q[k] rises at 1+200k, 1001+200k, 2001+200k; done single pulse at clock 3000 after start; q idle after; a second en pulse without going low does nothing.
- pulse_w=0, or pulse_w=1000 with cycle=1000, or stagger=400 with pulse_w=50 and cycle=1000 (3·400+50>1000) → cfg_err one cycle, busy stays 0, q idle.
- Continuous run, drop en mid-pulse → q idle within 1 cycle, no done; change cycle during RUN → period unchanged until the next start.
- ACTIVE_HIGH=0, cycle=10, pulse_w=9 → q[0] low 9 clocks, high 1 clock, period 10.
